clk_enable_sequencer: RTL and testbench

- Parametrised successor to the board PLL wrapper.
- Runs in the PLL output (sys_clk) domain. Qualifies the asynchronous PLL lock, then releases a synchronous-deassert domain reset after a programmable stable-lock interval.
- Generates NUM_CH independent fractional clock-enable strobes using phase-accumulator NCOs. This replaces extra PLL outputs for slow peripherals (UART, timer, SPI).
- Lock loss at runtime re-asserts the domain reset and records the event.

---
 rtl/clk_enable_sequencer.sv | 128 ++++++++++++
 tb/tb_clk_enable_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_sequencer.sv
// rtl/clk_enable_sequencer.sv - PLL lock qualifier, domain reset release and NCO clock-enable strobes
// Optional: define LOCK_LOSS_CNT_EN to add the saturating lock_loss_count output.
`timescale 1ns/1ps
module clk_enable_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic                    inc_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ce,
  output logic                    domain_rst_n,
  output logic                    ready,
  output logic                    lock_lost
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]              lock_loss_count
`endif
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE_COUNT,
    RUN
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_lk;
  logic                    w_run_next;
  logic [NUM_CH*ACC_W-1:0] r_shadow;
  logic [ACC_W-1:0]        r_acc [NUM_CH];
  logic [ACC_W:0]          w_sum [NUM_CH];

  assign w_lk       = r_sync[SYNC_STAGES-1];
  assign w_run_next = (w_next == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_HOLD:   w_next = WAIT_LOCK;
      WAIT_LOCK:    if (w_lk) w_next = STABLE_COUNT;
      STABLE_COUNT: begin
        if (!w_lk) begin
          w_next = WAIT_LOCK;
        end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          w_next = RUN;
        end
      end
      RUN:          if (!w_lk) w_next = WAIT_LOCK;
      default:      w_next = RESET_HOLD;
    endcase
  end

  // Outputs follow the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESET_HOLD;
      r_cnt        <= '0;
      domain_rst_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
`ifdef LOCK_LOSS_CNT_EN
      lock_loss_count <= 8'd0;
`endif
    end else begin
      r_state      <= w_next;
      domain_rst_n <= w_run_next;
      ready        <= w_run_next;
      if (r_state == STABLE_COUNT && w_next == STABLE_COUNT) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == RUN && !w_lk) begin
        lock_lost <= 1'b1;
`ifdef LOCK_LOSS_CNT_EN
        if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_shadow[i*ACC_W +: ACC_W]};
    end
  end

  // Retune keeps accumulator phase; the new increment applies from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      ce       <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else begin
      if (inc_load && r_state != RESET_HOLD) r_shadow <= inc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_run_next && ch_en[i]) begin
          r_acc[i] <= w_sum[i][ACC_W-1:0];
          ce[i]    <= w_sum[i][ACC_W];
        end else begin
          r_acc[i] <= '0;
          ce[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// tb/tb_clk_enable_sequencer.sv - directed self-checking bench for clk_enable_sequencer
`timescale 1ns/1ps
module tb_clk_enable_sequencer;
  localparam int NUM_CH = 2, ACC_W = 8, LOCK_CYCLES = 16, SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n, pll_locked, inc_load;
  logic [15:0] inc;
  logic [1:0]  ch_en, ce;
  logic        domain_rst_n, ready, lock_lost;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]  lock_loss_count;
`endif

  int checks = 0;
  int failures = 0;
  int edge_idx = 0;
  int c0, c1, fc;
  logic [1:0]  ce_or;
  logic [12:1] exp_rt;

  always #5 clk = ~clk;

  clk_enable_sequencer #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .inc(inc), .inc_load(inc_load),
    .ch_en(ch_en), .ce(ce), .domain_rst_n(domain_rst_n), .ready(ready), .lock_lost(lock_lost)
`ifdef LOCK_LOSS_CNT_EN
    , .lock_loss_count(lock_loss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    edge_idx++;
  endtask

  task automatic run_to(input int e);
    while (edge_idx < e) tick();
  endtask

  // Called at a negedge; the following posedge is edge 0 (enters WAIT_LOCK).
  task automatic release_reset();
    rst_n    = 1'b1;
    edge_idx = -1;
  endtask

  task automatic window(output int n0, output int n1, output int first);
    n0 = 0; n1 = 0; first = 0;
    for (int n = 1; n <= 256; n++) begin
      if (n > 1) tick();
      n0 += int'(ce[0]);
      n1 += int'(ce[1]);
      if (first == 0 && ce == 2'b11) first = n;
    end
  endtask

  task automatic restart_ch0(input logic [7:0] inc0);
    ch_en    = 2'b10;
    inc      = {8'h40, inc0};
    inc_load = 1'b1;
    tick();
    ch_en    = 2'b11;
    inc_load = 1'b0;
    tick();
  endtask

  task automatic lose_and_regain(input string tag);
    pll_locked = 1'b0;
    repeat (3) tick();
    check({tag, "_drst"}, 32'(domain_rst_n), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_ce"}, 32'(ce), 32'd0);
    check({tag, "_lost"}, 32'(lock_lost), 32'd1);
    pll_locked = 1'b1;
    repeat (18) tick();
    check({tag, "_early"}, 32'(ready), 32'd0);
    tick();
    check({tag, "_rerel"}, 32'({domain_rst_n, ready}), 32'h3);
    check({tag, "_sticky"}, 32'(lock_lost), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b1; inc_load = 1'b0; inc = '0; ch_en = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_outs", 32'({ce, domain_rst_n, ready, lock_lost}), 32'd0);
`ifdef LOCK_LOSS_CNT_EN
    check("rst_cnt", 32'(lock_loss_count), 32'd0);
`endif

    // Lock release and first rate window.
    @(negedge clk);
    release_reset();
    run_to(0);
    inc = {8'h40, 8'h80};
    inc_load = 1'b1;
    run_to(1);
    inc_load = 1'b0;
    ce_or = ce;
    while (edge_idx < 17) begin
      tick();
      ce_or |= ce;
    end
    check("qual_ce", 32'(ce_or), 32'd0);
    check("qual_e17", 32'({domain_rst_n, ready}), 32'd0);
    run_to(18);
    check("rel_e18", 32'({domain_rst_n, ready}), 32'h3);
    window(c0, c1, fc);
    check("rate_80", c0, 128);
    check("rate_40", c1, 64);
    check("first_coinc", fc, 4);

    restart_ch0(8'h00);
    window(c0, c1, fc);
    check("rate_00", c0, 0);
    check("rate_40b", c1, 64);
    restart_ch0(8'hFF);
    window(c0, c1, fc);
    check("rate_ff", c0, 255);

    // Retune 0x40 -> 0x80 with inc_load sampled on cycle 7's edge.
    exp_rt = 12'b1010_1000_1000;
    restart_ch0(8'h40);
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) tick();
      check($sformatf("retune_c%0d", n), 32'(ce[0]), 32'(exp_rt[n]));
      if (n == 6) begin
        inc = {8'h40, 8'h80};
        inc_load = 1'b1;
      end
      if (n == 7) inc_load = 1'b0;
    end

    check("pre_loss_lost", 32'(lock_lost), 32'd0);
    lose_and_regain("loss1");
`ifdef LOCK_LOSS_CNT_EN
    check("loss_cnt1", 32'(lock_loss_count), 32'd1);
`endif
    lose_and_regain("loss2");
    lose_and_regain("loss3");
`ifdef LOCK_LOSS_CNT_EN
    check("loss_cnt3", 32'(lock_loss_count), 32'd3);
`endif

    // Asynchronous reset in RUN.
    check("pre_rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({ce, domain_rst_n, ready, lock_lost}), 32'd0);
`ifdef LOCK_LOSS_CNT_EN
    check("async_rst_cnt", 32'(lock_loss_count), 32'd0);
`endif
    @(negedge clk);
    release_reset();
    run_to(0);
    inc = {8'h40, 8'h80};
    inc_load = 1'b1;
    run_to(1);
    inc_load = 1'b0;
    run_to(17);
    check("rerun_e17", 32'(ready), 32'd0);
    run_to(18);
    check("rerun_e18", 32'({domain_rst_n, ready, lock_lost}), 32'h6);

    // One-cycle lock glitch during qualification.
    rst_n = 1'b0;
    @(negedge clk);
    release_reset();
    run_to(11);
    pll_locked = 1'b0;
    run_to(12);
    pll_locked = 1'b1;
    run_to(18);
    check("glitch_e18", 32'(ready), 32'd0);
    run_to(30);
    check("glitch_e30", 32'(ready), 32'd0);
    run_to(31);
    check("glitch_e31", 32'({domain_rst_n, ready}), 32'h3);
    check("glitch_lost", 32'(lock_lost), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
